// File: rtl/multiplier_if.sv
// rtl/multiplier_if.sv - handshake/data bundle for the shift-add multiply-accumulate unit
interface multiplier_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] multiplicand_in;
   logic [WIDTH-1:0] multiplier_in;
   logic [WIDTH-1:0] addend_in;
   logic             data_valid_in;
   logic [WIDTH-1:0] result_out;
   logic             data_valid_out;
   logic             error_out;
   logic             busy_out;

   // Requester side: drives operands and the start strobe
   modport master (
      output multiplicand_in,
      output multiplier_in,
      output addend_in,
      output data_valid_in,
      input  result_out,
      input  data_valid_out,
      input  error_out,
      input  busy_out
   );

   // Unit side: samples operands, returns result and status
   modport slave (
      input  multiplicand_in,
      input  multiplier_in,
      input  addend_in,
      input  data_valid_in,
      output result_out,
      output data_valid_out,
      output error_out,
      output busy_out
   );
endinterface

// File: rtl/multiplier.sv
// rtl/multiplier.sv - sequential shift-add unit computing A*B+C in WIDTH cycles
module multiplier #(
   parameter int WIDTH = 32
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   multiplier_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, MULT} state_t;

   state_t             state_q, state_d;
   logic [2*WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0]   b_sh_q, b_sh_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               error_q, error_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic [2*WIDTH-1:0] acc_sum;

   // Next-state logic: load operands in IDLE, one add/shift per cycle in MULT
   always_comb begin
      state_d   = state_q;
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      acc_d     = acc_q;
      bit_cnt_d = bit_cnt_q;
      result_d  = result_q;
      error_d   = error_q;
      valid_d   = 1'b0;
      busy_d    = busy_q;
      // Accumulator is 2*WIDTH wide, so the worst-case A*B+C never wraps here
      acc_sum   = acc_q + (b_sh_q[0] ? a_sh_q : '0);

      case (state_q)
         IDLE: begin
            if (bus.data_valid_in) begin
               a_sh_d    = {{WIDTH{1'b0}}, bus.multiplicand_in};
               b_sh_d    = bus.multiplier_in;
               acc_d     = {{WIDTH{1'b0}}, bus.addend_in};
               bit_cnt_d = '0;
               busy_d    = 1'b1;
               state_d   = MULT;
            end
         end
         MULT: begin
            acc_d     = acc_sum;
            a_sh_d    = a_sh_q << 1;
            b_sh_d    = b_sh_q >> 1;
            bit_cnt_d = bit_cnt_q + CW'(1);
            // Last iteration also publishes the result; no early exit on zero operands
            if (bit_cnt_q == CW'(WIDTH - 1)) begin
               result_d = acc_sum[WIDTH-1:0];
               error_d  = |acc_sum[2*WIDTH-1:WIDTH];
               valid_d  = 1'b1;
               busy_d   = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation without a valid pulse
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= IDLE;
         a_sh_q    <= '0;
         b_sh_q    <= '0;
         acc_q     <= '0;
         bit_cnt_q <= '0;
         result_q  <= '0;
         error_q   <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_sh_q    <= a_sh_d;
         b_sh_q    <= b_sh_d;
         acc_q     <= acc_d;
         bit_cnt_q <= bit_cnt_d;
         result_q  <= result_d;
         error_q   <= error_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.result_out     = result_q;
   assign bus.error_out      = error_q;
   assign bus.data_valid_out = valid_q;
   assign bus.busy_out       = busy_q;
endmodule

// File: tb/tb_multiplier.sv
// tb/tb_multiplier.sv - self-checking bench for the multiply-accumulate unit
module tb_multiplier;
   localparam int W = 32;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] c;
      logic [W-1:0] res;
      logic         err;
   } vec_t;

   typedef struct {
      logic [W-1:0] res;
      logic         err;
      int           cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   failures;
   exp_t sb[$];

   multiplier_if #(.WIDTH(W)) bus ();

   multiplier #(.WIDTH(W)) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks = checks + 1;
      if (act !== req) begin
         failures = failures + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Scoreboard monitor: every completion pops one expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.data_valid_out) begin
            if (sb.size() == 0) begin
               checks = checks + 1;
               failures = failures + 1;
               $display("FAIL unexpected_valid: data_valid_out=1 with no pending request at cycle %0d", cyc);
            end else begin
               e = sb.pop_front();
               check("result", 64'(bus.result_out), 64'(e.res));
               check("error", 64'(bus.error_out), 64'(e.err));
               check("latency_cycle", 64'(cyc), 64'(e.cyc));
            end
         end
      end
   end

   task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
      exp_t e;
      logic [63:0] full;
      full  = 64'(a) * 64'(b) + 64'(c);
      e.res = full[W-1:0];
      e.err = |full[63:W];
      e.cyc = cyc + 1 + W;
      sb.push_back(e);
   endtask

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
      bus.multiplicand_in = a;
      bus.multiplier_in   = b;
      bus.addend_in       = c;
      bus.data_valid_in   = 1'b1;
   endtask

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
      @(negedge clk);
      drive(a, b, c);
      push_exp(a, b, c);
      @(negedge clk);
      bus.data_valid_in = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n = n + 1;
      end
      if (sb.size() != 0) begin
         checks = checks + 1;
         failures = failures + 1;
         $display("FAIL drain_timeout: %0d results still pending", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   vec_t vecs[12];

   initial begin
      int   base;
      logic seen;
      logic [W-1:0] ra, rb, rc;

      vecs[0]  = '{a: 32'h0000_1234, b: 32'h0,         c: 32'h99,        res: 32'h99,        err: 1'b0};
      vecs[1]  = '{a: 32'h0001_0000, b: 32'h0001_0000, c: 32'h0,         res: 32'h0,         err: 1'b1};
      vecs[2]  = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, c: 32'hFFFF_FFFF, res: 32'h0,         err: 1'b1};
      vecs[3]  = '{a: 32'd142,       b: 32'd7,         c: 32'd6,         res: 32'd1000,      err: 1'b0};
      vecs[4]  = '{a: 32'h0,         b: 32'hFFFF_FFFF, c: 32'hFFFF_FFFF, res: 32'hFFFF_FFFF, err: 1'b0};
      vecs[5]  = '{a: 32'hFFFF_FFFF, b: 32'h1,         c: 32'h1,         res: 32'h0,         err: 1'b1};
      vecs[6]  = '{a: 32'hFFFF_FFFF, b: 32'h1,         c: 32'h0,         res: 32'hFFFF_FFFF, err: 1'b0};
      vecs[7]  = '{a: 32'h0001_0000, b: 32'h0000_FFFF, c: 32'h0000_FFFF, res: 32'hFFFF_FFFF, err: 1'b0};
      vecs[8]  = '{a: 32'd3,         b: 32'd5,         c: 32'd0,         res: 32'd15,        err: 1'b0};
      vecs[9]  = '{a: 32'h8000_0000, b: 32'h2,         c: 32'h0,         res: 32'h0,         err: 1'b1};
      vecs[10] = '{a: 32'd12345,     b: 32'd6789,      c: 32'd1000,      res: 32'd83811205,  err: 1'b0};
      vecs[11] = '{a: 32'h0,         b: 32'h0,         c: 32'h0,         res: 32'h0,         err: 1'b0};

      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.multiplicand_in = '0;
      bus.multiplier_in   = '0;
      bus.addend_in       = '0;
      bus.data_valid_in   = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_result", 64'(bus.result_out), 64'h0);
      check("reset_valid", 64'(bus.data_valid_out), 64'h0);
      check("reset_error", 64'(bus.error_out), 64'h0);
      check("reset_busy", 64'(bus.busy_out), 64'h0);
      rst_n = 1'b1;

      // 7*6+5 with a cycle-by-cycle busy check across the whole operation
      @(negedge clk);
      drive(32'd7, 32'd6, 32'd5);
      push_exp(32'd7, 32'd6, 32'd5);
      base = cyc;
      sb[0].res = 32'd47;
      @(negedge clk);
      bus.data_valid_in = 1'b0;
      seen = 1'b1;
      for (int i = 0; i < W; i++) begin
         if (bus.busy_out !== 1'b1 || bus.data_valid_out !== 1'b0) seen = 1'b0;
         @(negedge clk);
      end
      check("busy_during_mult", 64'(seen), 64'h1);
      check("busy_after_done", 64'(bus.busy_out), 64'h0);
      check("done_cycle", 64'(cyc - base), 64'(W + 1));
      wait_drain();

      // Table of vectors; expectations come from the table, not the model
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         drive(vecs[i].a, vecs[i].b, vecs[i].c);
         push_exp(vecs[i].a, vecs[i].b, vecs[i].c);
         sb[sb.size()-1].res = vecs[i].res;
         sb[sb.size()-1].err = vecs[i].err;
         @(negedge clk);
         bus.data_valid_in = 1'b0;
         wait_drain();
      end

      // Random operands checked against the 64-bit reference
      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = (i < 3) ? 32'($urandom_range(0, 65535)) : $urandom;
         rc = $urandom;
         start_op(ra, rb, rc);
         wait_drain();
      end

      // Start during MULT is ignored; start in the valid cycle is accepted
      start_op(32'd3, 32'd4, 32'd0);
      repeat (9) @(negedge clk);
      drive(32'd100, 32'd4, 32'd0);
      @(negedge clk);
      bus.data_valid_in = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (bus.data_valid_out) seen = 1'b1;
      end
      check("first_completion_seen", 64'(seen), 64'h1);
      drive(32'd2, 32'd2, 32'd1);
      push_exp(32'd2, 32'd2, 32'd1);
      @(negedge clk);
      bus.data_valid_in = 1'b0;
      check("busy_after_b2b_accept", 64'(bus.busy_out), 64'h1);
      wait_drain();

      // Asynchronous reset mid-MULT clears outputs immediately and suppresses completion
      start_op(32'd5, 32'd5, 32'd0);
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_result", 64'(bus.result_out), 64'h0);
      check("async_rst_valid", 64'(bus.data_valid_out), 64'h0);
      check("async_rst_error", 64'(bus.error_out), 64'h0);
      check("async_rst_busy", 64'(bus.busy_out), 64'h0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.data_valid_out) seen = 1'b1;
      end
      check("no_valid_after_abort", 64'(seen), 64'h0);
      start_op(32'd5, 32'd5, 32'd0);
      sb[0].res = 32'd25;
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
